// File: rtl/inst_rom_resp.sv
// Instruction-memory responder: accepts word fetches, returns the word after LATENCY cycles
// with a one-cycle valid strobe; a side load port programs the array.
module inst_rom_resp #(
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter int unsigned LATENCY    = 1,
   parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic [31:0] addr,
   output logic        ready,
   output logic [31:0] inst,
   output logic        inst_valid,
   output logic        inst_err,
   input  logic        ld_we,
   input  logic [31:0] ld_addr,
   input  logic [31:0] ld_data
);

   localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [2:0]  CNT_LAST = 3'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                state, state_n;
   logic [2:0]            cnt, cnt_n;
   logic [31:0]           mem [DEPTH];

   logic                  acc_p0;
   logic                  err_p0;
   logic [DEPTH_LOG2-1:0] idx_p0;
   logic [31:0]           word_p0;

   logic                  err_p1;
   logic [31:0]           word_p1;

   logic                  resp_n;
   logic                  resp_err_n;
   logic [31:0]           resp_word_n;

   logic [DEPTH_LOG2-1:0] ld_idx;
   logic                  unused_ld_lsb;

   function automatic logic out_of_range(input logic [31:0] a);
      return a[31:DEPTH_LOG2+2] != '0;
   endfunction

   function automatic logic fetch_err(input logic [31:0] a);
      return (a[1:0] != 2'b00) || out_of_range(a);
   endfunction

   // p0: acceptance, decode and array read (old contents win on a same-edge load)
   assign ready   = (state == IDLE) || (state == RESP);
   assign acc_p0  = ce && ready;
   assign idx_p0  = addr[DEPTH_LOG2+1:2];
   assign err_p0  = fetch_err(addr);
   assign word_p0 = err_p0 ? NOP_WORD : mem[idx_p0];

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      resp_n      = 1'b0;
      resp_word_n = word_p1;
      resp_err_n  = err_p1;
      unique case (state)
         IDLE, RESP: begin
            state_n = IDLE;
            cnt_n   = '0;
            if (acc_p0) begin
               if (LATENCY == 1) begin
                  // No holding stage: the decoded word goes straight to the output
                  state_n     = RESP;
                  resp_n      = 1'b1;
                  resp_word_n = word_p0;
                  resp_err_n  = err_p0;
               end else begin
                  state_n = WAIT;
                  cnt_n   = 3'd1;
               end
            end
         end
         WAIT: begin
            if (cnt == CNT_LAST) begin
               state_n = RESP;
               resp_n  = 1'b1;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 3'd1;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         inst       <= '0;
         inst_valid <= 1'b0;
         inst_err   <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         inst_valid <= resp_n;
         inst_err   <= resp_n & resp_err_n;
         if (resp_n) begin
            inst <= resp_word_n;
         end
      end
   end

   // p1: holding register for the word while the request waits out its latency
   always_ff @(posedge clk) begin
      if (acc_p0) begin
         word_p1 <= word_p0;
         err_p1  <= err_p0;
      end
   end

   // Load port: byte lane bits are ignored, out-of-range writes are dropped
   assign ld_idx        = ld_addr[DEPTH_LOG2+1:2];
   assign unused_ld_lsb = ^ld_addr[1:0];

   always_ff @(posedge clk) begin
      if (ld_we && !out_of_range(ld_addr)) begin
         mem[ld_idx] <= ld_data;
      end
   end

endmodule

// File: tb/tb_inst_rom_resp.sv
// Bench for inst_rom_resp at LATENCY 1, 3 and 4 against a cycle-numbered reference model.
module tb_inst_rom_resp;

   logic        clk = 1'b0;
   logic [2:0]  rst;
   logic [2:0]  ce;
   logic [31:0] addr [3];
   logic        ld_we;
   logic [31:0] ld_addr, ld_data;
   logic        ready_o [3];
   logic [31:0] inst_o [3];
   logic        valid_o [3];
   logic        err_o [3];

   int checks = 0;
   int failures = 0;

   // reference model: edge number n, per-instance next legal acceptance edge and pending response
   int          n = 0;
   logic [31:0] mem_m [1024];
   int          next_acc [3];
   int          resp_edge [3];
   bit          pend [3];
   logic [31:0] resp_data [3];
   bit          resp_err [3];
   logic [31:0] last_inst [3];

   always #5 clk = ~clk;

   inst_rom_resp #(.LATENCY(1)) u_l1 (
      .clk(clk), .rst(rst[0]), .ce(ce[0]), .addr(addr[0]), .ready(ready_o[0]),
      .inst(inst_o[0]), .inst_valid(valid_o[0]), .inst_err(err_o[0]),
      .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));

   inst_rom_resp #(.LATENCY(3)) u_l3 (
      .clk(clk), .rst(rst[1]), .ce(ce[1]), .addr(addr[1]), .ready(ready_o[1]),
      .inst(inst_o[1]), .inst_valid(valid_o[1]), .inst_err(err_o[1]),
      .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));

   inst_rom_resp #(.LATENCY(4)) u_l4 (
      .clk(clk), .rst(rst[2]), .ce(ce[2]), .addr(addr[2]), .ready(ready_o[2]),
      .inst(inst_o[2]), .inst_valid(valid_o[2]), .inst_err(err_o[2]),
      .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));

   function automatic int lat(input int i);
      return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic model_reset(input int i);
      pend[i]      = 1'b0;
      next_acc[i]  = 0;
      last_inst[i] = '0;
   endtask

   task automatic check_all();
      for (int i = 0; i < 3; i++) begin
         bit ev;
         ev = pend[i] && (n == resp_edge[i]);
         chk($sformatf("valid_l%0d_n%0d", lat(i), n), {31'b0, valid_o[i]}, {31'b0, ev});
         chk($sformatf("inst_l%0d_n%0d", lat(i), n), inst_o[i], ev ? resp_data[i] : last_inst[i]);
         chk($sformatf("err_l%0d_n%0d", lat(i), n), {31'b0, err_o[i]}, {31'b0, ev & resp_err[i]});
         chk($sformatf("ready_l%0d_n%0d", lat(i), n), {31'b0, ready_o[i]},
             {31'b0, (n + 1 >= next_acc[i])});
         if (ev) begin
            last_inst[i] = resp_data[i];
            pend[i]      = 1'b0;
         end
      end
   endtask

   // One clock: predict acceptance for the coming edge, apply the load after the read, then check
   task automatic tick();
      for (int i = 0; i < 3; i++) begin
         if (rst[i] && ce[i] && (n + 1 >= next_acc[i])) begin
            bit e;
            e = (addr[i][1:0] != 2'b00) || (addr[i][31:12] != 20'h0);
            resp_data[i] = e ? 32'h0 : mem_m[addr[i][11:2]];
            resp_err[i]  = e;
            resp_edge[i] = n + lat(i);
            pend[i]      = 1'b1;
            next_acc[i]  = n + 1 + lat(i);
         end
      end
      if (ld_we && ld_addr[31:12] == 20'h0) mem_m[ld_addr[11:2]] = ld_data;
      @(posedge clk);
      n++;
      @(negedge clk);
      check_all();
   endtask

   task automatic load(input logic [31:0] a, input logic [31:0] d);
      ld_we = 1'b1; ld_addr = a; ld_data = d;
      tick();
      ld_we = 1'b0;
   endtask

   initial begin
      rst = 3'b000; ce = 3'b000; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
      for (int i = 0; i < 3; i++) begin
         addr[i] = '0;
         model_reset(i);
      end

      // reset state, with the load port programming words 0..15 while held in reset
      @(negedge clk);
      check_all();
      for (int w = 0; w < 16; w++) load(32'(w * 4), 32'hC0DE_0000 + 32'(w));
      rst = 3'b111;
      tick();

      // LATENCY=1 stream of four words
      load(32'h0, 32'h11); load(32'h4, 32'h22); load(32'h8, 32'h33); load(32'hC, 32'h44);
      ce[0] = 1'b1;
      for (int w = 0; w < 4; w++) begin
         addr[0] = 32'(w * 4);
         tick();
      end
      ce[0] = 1'b0;
      tick();
      chk("stream_last_word", last_inst[0] == 32'h44 ? inst_o[0] : 32'hDEAD, 32'h44);

      // LATENCY=3 spacing with ce held high
      ce[1] = 1'b1; addr[1] = 32'h4;
      repeat (10) tick();
      ce[1] = 1'b0;
      repeat (3) tick();

      // error responses, then confirm the array is unchanged
      ce[0] = 1'b1; addr[0] = 32'h2; tick();
      addr[0] = 32'h0000_1000; tick();
      for (int w = 0; w < 4; w++) begin
         addr[0] = 32'(w * 4);
         tick();
      end
      ce[0] = 1'b0; tick();

      // read/write collision: old word first, new word on the next fetch
      load(32'h4, 32'hAAAA_0000);
      ld_we = 1'b1; ld_addr = 32'h4; ld_data = 32'hBBBB_0000;
      ce[0] = 1'b1; addr[0] = 32'h4;
      tick();
      ld_we = 1'b0;
      tick();
      ce[0] = 1'b0;
      tick();
      chk("collision_new_word", inst_o[0], 32'hBBBB_0000);
      load(32'h4, 32'h22);

      // asynchronous reset one cycle after acceptance on LATENCY=3
      ce[1] = 1'b1; addr[1] = 32'h8; tick();
      ce[1] = 1'b0; tick();
      #2 rst[1] = 1'b0;
      model_reset(1);
      #1;
      chk("async_rst_inst", inst_o[1], 32'h0);
      chk("async_rst_valid", {31'b0, valid_o[1]}, 32'h0);
      chk("async_rst_ready", {31'b0, ready_o[1]}, 32'h1);
      @(negedge clk);
      tick();
      rst[1] = 1'b1;
      repeat (4) tick();
      ce[1] = 1'b1; addr[1] = 32'h8; tick();
      ce[1] = 1'b0; repeat (3) tick();
      chk("mem2_retained", inst_o[1], 32'h33);

      // ce dropped during WAIT on LATENCY=4
      ce[2] = 1'b1; addr[2] = 32'hC; tick();
      ce[2] = 1'b0; repeat (5) tick();
      chk("l4_resp_word", inst_o[2], 32'h44);

      // randomized traffic on all three instances
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 3; i++) begin
            int r;
            ce[i] = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            if (r < 7)       addr[i] = 32'($urandom_range(0, 15)) << 2;
            else if (r == 7) addr[i] = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
            else if (r == 8) addr[i] = (32'h1 << $urandom_range(12, 31)) | (32'($urandom_range(0, 15)) << 2);
            else             addr[i] = 32'h0;
         end
         ld_we   = ($urandom_range(0, 3) == 0);
         ld_addr = ($urandom_range(0, 7) == 0) ? (32'h1 << $urandom_range(12, 31))
                                               : ((32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3)));
         ld_data = $urandom;
         tick();
      end
      ce = 3'b000; ld_we = 1'b0;
      repeat (6) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
